// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and TX FSM states for mmio_uart_tx
package uart_pkg;
    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] CTRL_OFF   = 4'h8;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_LVL   = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: core data-memory bus as seen by a memory-mapped responder
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic        re;
    modport master (output addr, wdata, we, re, input rdata);
    modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is accepted only if a pop frees a slot that cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr_ok, rd_ok;
    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign dout  = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) rp <= rp + AW'(1);
            level <= level + LW'(wr_ok) - LW'(rd_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO
// Optional interrupt and CTRL register enabled by defining UART_TX_IRQ_EN.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          irq
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);
    logic sel, wr_tx, wr_st, pop, full, empty, ovf, irq_en, unused_wdata;
    logic [3:0] off;
    logic [7:0] dout, shift;
    logic [LW-1:0] level;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [31:0] lvl, status;
    uart_tx_state_t state;
    assign sel   = bus.addr[31:4] == BASE_ADDR[31:4];
    assign off   = bus.addr[3:0];
    assign wr_tx = sel && bus.we && off == TXDATA_OFF;
    assign wr_st = sel && bus.we && off == STATUS_OFF;
    assign unused_wdata = &{1'b0, bus.wdata[31:8]};
    // The FSM drains the FIFO both from IDLE and straight out of a finished STOP bit
    assign pop = !empty && (state == IDLE || (state == STOP && cnt == '0));
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(wr_tx), .pop(pop), .din(bus.wdata[7:0]),
        .dout(dout), .full(full), .empty(empty), .level(level)
    );
    assign lvl    = 32'(level);
    assign status = (32'(full) << ST_FULL) | (32'(empty) << ST_EMPTY) |
                    (32'(state != IDLE) << ST_BUSY) | (32'(ovf) << ST_OVF) |
                    ((lvl > 32'd15 ? 32'd15 : lvl) << ST_LVL);
    assign bus.rdata = !(sel && bus.re) ? 32'd0 :
                       off == STATUS_OFF ? status :
                       off == CTRL_OFF   ? 32'(irq_en) : 32'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else if (wr_tx && full && !pop) ovf <= 1'b1;
        else if (wr_st && bus.wdata[ST_OVF]) ovf <= 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (!empty) begin
                    state <= START;
                    cnt   <= LOAD;
                    shift <= dout;
                    tx    <= 1'b0;
                end
                START: if (cnt != '0) cnt <= cnt - CW'(1);
                else begin
                    state <= DATA;
                    cnt   <= LOAD;
                    tx    <= shift[0];
                end
                DATA: if (cnt != '0) cnt <= cnt - CW'(1);
                else begin
                    cnt     <= LOAD;
                    bit_idx <= bit_idx + 3'd1;
                    shift   <= shift >> 1;
                    tx      <= bit_idx == 3'd7 ? 1'b1 : shift[1];
                    state   <= bit_idx == 3'd7 ? STOP : DATA;
                end
                STOP: if (cnt != '0) cnt <= cnt - CW'(1);
                else if (!empty) begin
                    state <= START;
                    cnt   <= LOAD;
                    shift <= dout;
                    tx    <= 1'b0;
                end else state <= IDLE;
            endcase
        end
    end
`ifdef UART_TX_IRQ_EN
    logic wr_ctrl;
    assign wr_ctrl = sel && bus.we && off == CTRL_OFF;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= bus.wdata[0];
            irq <= irq_en && empty && state == IDLE;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized checks of mmio_uart_tx against a frame-level line model
// Covers both builds: with and without UART_TX_IRQ_EN.
module tb_mmio_uart_tx;
    localparam int D = 4;
    localparam int F = 10 * D;
    localparam logic [31:0] BA = 32'h1000_0000;
    logic clk = 1'b0, rst = 1'b1, tx, irq;
    int n_chk = 0, n_pass = 0;
    mmio_uart_tx_if bus ();
    mmio_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(8), .BASE_ADDR(BA)) dut (
        .clk(clk), .rst(rst), .bus(bus), .tx(tx), .irq(irq)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a; bus.re = 1'b1;
        #1 d = bus.rdata;
        bus.re = 1'b0;
    endtask

    function automatic logic [31:0] st(input bit f, input bit e, input bit b, input bit o, input int l);
        return {20'd0, 4'(l), 4'd0, o, b, e, f};
    endfunction

    // Line level i cycles after the first frame starts, for back-to-back 8N1 frames of q
    function automatic logic line_bit(input logic [7:0] q[$], input int i);
        int k = i / F, b = (i % F) / D;
        return b == 0 ? 1'b0 : b == 9 ? 1'b1 : q[k][b-1];
    endfunction

    task automatic expect_line(input logic [7:0] q[$], input int i0, input bit lv);
        logic [31:0] s;
        int n = q.size();
        for (int i = i0; i < n * F; i++) begin
            @(negedge clk);
            check($sformatf("tx[%0d]", i), 32'(tx), 32'(line_bit(q, i)));
            if (i % F == 2) begin
                rd(BA + 32'h4, s);
                check($sformatf("busy[%0d]", i), 32'(s[2]), 32'd1);
                if (lv) begin
                    check($sformatf("level[%0d]", i), 32'(s[11:8]), 32'(n - 1 - i / F));
                    check($sformatf("empty[%0d]", i), 32'(s[1]), 32'(n - 1 - i / F == 0));
                end
            end
        end
    endtask

    initial begin
        logic [31:0] s;
        logic [7:0] q[$];
        int n;
        bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        rd(BA + 32'h4, s); check("reset_status", s, st(0, 1, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);
        rd(BA + 32'h8, s); check("ctrl_reset", s, 32'd0);
        rd(BA, s); check("txdata_reads0", s, 32'd0);
        rd(BA + 32'hC, s); check("off_c_reads0", s, 32'd0);
        bus.addr = BA + 32'h4; bus.re = 1'b0;
        #1 check("re_low", bus.rdata, 32'd0);
        rd(BA + 32'h104, s); check("unselected_read", s, 32'd0);
        wr(BA + 32'h100, 32'h55);
        rd(BA + 32'h4, s); check("unselected_write", s, st(0, 1, 0, 0, 0));

        // single 0xA5 frame
        q = {8'hA5};
        wr(BA, 32'hA5);
        check("pre_start_tx", 32'(tx), 32'd1);
        expect_line(q, 0, 1'b1);
        @(negedge clk);
        rd(BA + 32'h4, s); check("a5_idle", s, st(0, 1, 0, 0, 0));

        // three back-to-back bytes
        q = {};
        for (int k = 0; k < 3; k++) q.push_back(8'($urandom));
        foreach (q[k]) wr(BA, 32'(q[k]));
        expect_line(q, 2, 1'b1);
        @(negedge clk);
        rd(BA + 32'h4, s); check("b2b_idle", s, st(0, 1, 0, 0, 0));

        // randomized bursts
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(2, 8);
            q = {};
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            foreach (q[k]) wr(BA, 32'(q[k]));
            expect_line(q, n - 1, 1'b0);
            @(negedge clk);
            rd(BA + 32'h4, s); check($sformatf("rand_idle%0d", r), s, st(0, 1, 0, 0, 0));
        end

        // overflow, clear, and push coincident with the STOP-end pop
        q = {8'($urandom)};
        wr(BA, 32'(q[0]));
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] b = 8'($urandom);
            if (k < 8) q.push_back(b);
            wr(BA, 32'(b));
        end
        rd(BA + 32'h4, s); check("ovf_status", s, st(1, 0, 1, 1, 8));
        wr(BA + 32'h4, 32'h8);
        rd(BA + 32'h4, s); check("ovf_cleared", s, st(1, 0, 1, 0, 8));
        repeat (29) @(negedge clk);
        q.push_back(8'($urandom));
        wr(BA, 32'(q[9]));
        rd(BA + 32'h4, s); check("full_push_pop", s, st(1, 0, 1, 0, 8));
        expect_line(q, 41, 1'b0);
        @(negedge clk);
        rd(BA + 32'h4, s); check("ovf_drained", s, st(0, 1, 0, 0, 0));

        // async reset mid-DATA discards queued bytes
        wr(BA, 32'h00); wr(BA, 32'h11); wr(BA, 32'h22);
        repeat (10) @(negedge clk);
        check("pre_rst_tx", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1 check("rst_tx_async", 32'(tx), 32'd1);
        rd(BA + 32'h4, s); check("rst_status", s, st(0, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        rd(BA + 32'h4, s); check("post_rst_status", s, st(0, 1, 0, 0, 0));
        q = {8'h3C};
        wr(BA, 32'h3C);
        expect_line(q, 0, 1'b1);
        @(negedge clk);
        rd(BA + 32'h4, s); check("post_rst_idle", s, st(0, 1, 0, 0, 0));

`ifdef UART_TX_IRQ_EN
        wr(BA + 32'h8, 32'h1);
        rd(BA + 32'h8, s); check("ctrl_rw", s, 32'd1);
        @(negedge clk);
        check("irq_idle", 32'(irq), 32'd1);
        wr(BA, 32'h5A);
        @(negedge clk);
        check("irq_after_push", 32'(irq), 32'd0);
        repeat (39) @(negedge clk);
        check("irq_stop", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_idle_entry", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_raised", 32'(irq), 32'd1);
        wr(BA + 32'h8, 32'h0);
        @(negedge clk);
        check("irq_disabled", 32'(irq), 32'd0);
`else
        wr(BA + 32'h8, 32'h1);
        rd(BA + 32'h8, s); check("ctrl_ignored", s, 32'd0);
        wr(BA, 32'h5A);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k % 5 == 0) check($sformatf("irq_tied[%0d]", k), 32'(irq), 32'd0);
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
